// File: rtl/raw_frame_assembler_pkg.sv
// raw_frame_assembler shared definitions.
// Default widths, counter sizing helper and FSM encodings.
package raw_frame_assembler_pkg;

  localparam int DEF_RAW_WIDTH      = 8;
  localparam int DEF_INPUT_CHANNELS = 4;
  localparam int DEF_MODE_WIDTH     = 2;
  localparam int DEF_LABEL_WIDTH    = 4;

  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // a single-channel frame still needs a 1-bit counter vector
  function automatic int cntWidth(input int ch);
    return (ch > 1) ? ceilLog2(ch) : 1;
  endfunction

  typedef enum logic {
    RFA_COLLECT = 1'b0,
    RFA_FULL    = 1'b1
  } rfaState_t;

endpackage

// File: rtl/raw_frame_assembler_if.sv
// raw_frame_assembler handshake bundles.
// Serial sample input and parallel frame output.
interface rfa_sample_if #(
  parameter int RAW_WIDTH   = raw_frame_assembler_pkg::DEF_RAW_WIDTH,
  parameter int MODE_WIDTH  = raw_frame_assembler_pkg::DEF_MODE_WIDTH,
  parameter int LABEL_WIDTH = raw_frame_assembler_pkg::DEF_LABEL_WIDTH
);
  logic                   SampleValid_SI;
  logic                   SampleReady_SO;
  logic                   FrameStart_SI;
  logic [RAW_WIDTH-1:0]   Sample_DI;
  logic [MODE_WIDTH-1:0]  ModeIn_SI;
  logic [LABEL_WIDTH-1:0] LabelIn_DI;

  modport master (
    output SampleValid_SI, FrameStart_SI, Sample_DI,
    output ModeIn_SI, LabelIn_DI,
    input  SampleReady_SO
  );

  modport slave (
    input  SampleValid_SI, FrameStart_SI, Sample_DI,
    input  ModeIn_SI, LabelIn_DI,
    output SampleReady_SO
  );
endinterface

interface rfa_frame_if #(
  parameter int RAW_WIDTH      = raw_frame_assembler_pkg::DEF_RAW_WIDTH,
  parameter int INPUT_CHANNELS = raw_frame_assembler_pkg::DEF_INPUT_CHANNELS,
  parameter int MODE_WIDTH     = raw_frame_assembler_pkg::DEF_MODE_WIDTH,
  parameter int LABEL_WIDTH    = raw_frame_assembler_pkg::DEF_LABEL_WIDTH
);
  logic                                ValidOut_SO;
  logic                                ReadyIn_SI;
  logic [RAW_WIDTH*INPUT_CHANNELS-1:0] Raw_DO;
  logic [MODE_WIDTH-1:0]               ModeOut_SO;
  logic [LABEL_WIDTH-1:0]              LabelOut_DO;

  modport master (
    output ValidOut_SO, Raw_DO, ModeOut_SO, LabelOut_DO,
    input  ReadyIn_SI
  );

  modport slave (
    input  ValidOut_SO, Raw_DO, ModeOut_SO, LabelOut_DO,
    output ReadyIn_SI
  );
endinterface

// File: rtl/raw_frame_assembler_frame_output_reg.sv
// frame_output_reg: one-entry valid/ready holding register.
// Accepts a new word whenever empty or draining this cycle.
module frame_output_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_CI,
  input  logic             Reset_RBI,
  input  logic             LoadValid_SI,
  output logic             LoadReady_SO,
  input  logic [WIDTH-1:0] LoadData_DI,
  output logic             Valid_SO,
  input  logic             Ready_SI,
  output logic [WIDTH-1:0] Data_DO
);

  logic load;

  assign LoadReady_SO = !Valid_SO || Ready_SI;
  assign load         = LoadValid_SI && LoadReady_SO;

  // hold data until consumed; refill on the draining edge
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      Valid_SO <= 1'b0;
      Data_DO  <= '0;
    end else if (load) begin
      Valid_SO <= 1'b1;
      Data_DO  <= LoadData_DI;
    end else if (Ready_SI) begin
      Valid_SO <= 1'b0;
    end
  end

endmodule

// File: rtl/raw_frame_assembler.sv
// raw_frame_assembler: serial channel samples to parallel frames.
// Gathers the next frame while the previous one waits downstream.
module raw_frame_assembler
  import raw_frame_assembler_pkg::*;
#(
  parameter int RAW_WIDTH      = DEF_RAW_WIDTH,
  parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter int MODE_WIDTH     = DEF_MODE_WIDTH,
  parameter int LABEL_WIDTH    = DEF_LABEL_WIDTH
) (
  input  logic       Clk_CI,
  input  logic       Reset_RBI,
  rfa_sample_if.slave sampleIf,
  rfa_frame_if.master frameIf,
  output logic       FrameErr_SO
);

  localparam int CNT_W   = cntWidth(INPUT_CHANNELS);
  localparam int FRAME_W = RAW_WIDTH * INPUT_CHANNELS;
  localparam int OUT_W   = MODE_WIDTH + LABEL_WIDTH + FRAME_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_CHANNELS - 1);

  rfaState_t                                state;
  logic [CNT_W-1:0]                         cnt;
  logic [INPUT_CHANNELS-1:0][RAW_WIDTH-1:0] slots;
  logic [MODE_WIDTH-1:0]                    asmMode;
  logic [LABEL_WIDTH-1:0]                   asmLabel;
  logic                                     sampleReady;

  logic                                     accept;
  logic [CNT_W-1:0]                         idx;
  logic                                     lastSample;
  logic [INPUT_CHANNELS-1:0][RAW_WIDTH-1:0] slotsNext;
  logic [MODE_WIDTH-1:0]                    modeNext;
  logic [LABEL_WIDTH-1:0]                   labelNext;
  logic                                     loadValid;
  logic                                     loadReady;
  logic [OUT_W-1:0]                         loadData;
  logic [OUT_W-1:0]                         outData;

  assign accept     = sampleIf.SampleValid_SI && sampleReady;
  assign idx        = sampleIf.FrameStart_SI ? '0 : cnt;
  assign lastSample = (idx == LAST_IDX);

  assign sampleIf.SampleReady_SO = sampleReady;

  // frame as it will look after this cycle's sample lands
  always_comb begin
    slotsNext = slots;
    modeNext  = asmMode;
    labelNext = asmLabel;
    if (accept) begin
      slotsNext[idx] = sampleIf.Sample_DI;
      if (idx == '0) begin
        modeNext  = sampleIf.ModeIn_SI;
        labelNext = sampleIf.LabelIn_DI;
      end
    end
  end

  // a parked frame takes priority; in FULL no sample is accepted
  assign loadValid = (state == RFA_FULL) || (accept && lastSample);
  assign loadData  = {modeNext, labelNext, slotsNext};

  // assembly FSM with registered ready and resync pulse
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state       <= RFA_COLLECT;
      cnt         <= '0;
      slots       <= '0;
      asmMode     <= '0;
      asmLabel    <= '0;
      sampleReady <= 1'b0;
      FrameErr_SO <= 1'b0;
    end else begin
      FrameErr_SO <= accept && sampleIf.FrameStart_SI
                     && (cnt != '0);
      slots       <= slotsNext;
      asmMode     <= modeNext;
      asmLabel    <= labelNext;
      unique case (state)
        RFA_COLLECT: begin
          sampleReady <= 1'b1;
          if (accept) begin
            if (lastSample) begin
              cnt <= '0;
              if (!loadReady) begin
                state       <= RFA_FULL;
                sampleReady <= 1'b0;
              end
            end else begin
              cnt <= idx + CNT_W'(1);
            end
          end
        end
        RFA_FULL: begin
          sampleReady <= 1'b0;
          if (loadReady) begin
            state       <= RFA_COLLECT;
            sampleReady <= 1'b1;
          end
        end
      endcase
    end
  end

  frame_output_reg #(
    .WIDTH(OUT_W)
  ) u_outReg (
    .Clk_CI       (Clk_CI),
    .Reset_RBI    (Reset_RBI),
    .LoadValid_SI (loadValid),
    .LoadReady_SO (loadReady),
    .LoadData_DI  (loadData),
    .Valid_SO     (frameIf.ValidOut_SO),
    .Ready_SI     (frameIf.ReadyIn_SI),
    .Data_DO      (outData)
  );

  assign {frameIf.ModeOut_SO, frameIf.LabelOut_DO, frameIf.Raw_DO} = outData;

endmodule

// File: tb/tb_raw_frame_assembler.sv
// tb_raw_frame_assembler: vector table, corner sequences, scoreboard.
// Expected frames are queued at stimulus time, popped on transfer.
module tb_raw_frame_assembler;

  localparam int RW  = 8;
  localparam int NCH = 4;
  localparam int MW  = 2;
  localparam int LW  = 4;

  typedef struct {
    logic [NCH*RW-1:0] raw;
    logic [MW-1:0]     mode;
    logic [LW-1:0]     label;
  } exp_t;

  typedef struct {
    logic              fs;
    logic [RW-1:0]     s0, s1, s2, s3;
    logic [MW-1:0]     mode;
    logic [LW-1:0]     label;
    logic [NCH*RW-1:0] expRaw;
  } vec_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic frameErr;

  int   checks = 0;
  int   errors = 0;
  int   errPulses = 0;
  int   cyc = 0;
  bit   streamOn = 0;
  exp_t sbQ[$];
  int   xferCyc[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  rfa_sample_if #(
    .RAW_WIDTH(RW), .MODE_WIDTH(MW), .LABEL_WIDTH(LW)
  ) sIf ();

  rfa_frame_if #(
    .RAW_WIDTH(RW), .INPUT_CHANNELS(NCH),
    .MODE_WIDTH(MW), .LABEL_WIDTH(LW)
  ) fIf ();

  raw_frame_assembler #(
    .RAW_WIDTH(RW), .INPUT_CHANNELS(NCH),
    .MODE_WIDTH(MW), .LABEL_WIDTH(LW)
  ) dut (
    .Clk_CI      (clk),
    .Reset_RBI   (rstN),
    .sampleIf    (sIf.slave),
    .frameIf     (fIf.master),
    .FrameErr_SO (frameErr)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic send(input logic fs, input logic [RW-1:0] d,
                      input logic [MW-1:0] m, input logic [LW-1:0] l);
    bit ok;
    ok = 0;
    @(negedge clk);
    sIf.SampleValid_SI = 1'b1;
    sIf.FrameStart_SI  = fs;
    sIf.Sample_DI      = d;
    sIf.ModeIn_SI      = m;
    sIf.LabelIn_DI     = l;
    for (int i = 0; i < 50; i++) begin
      if (sIf.SampleReady_SO) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%0h", d);
    end
    @(posedge clk);
    #1;
    sIf.SampleValid_SI = 1'b0;
    sIf.FrameStart_SI  = 1'b0;
  endtask

  function automatic logic [RW-1:0] streamData(input int f, input int k);
    return RW'((f * 16 + k) ^ 8'h5A);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstN) begin
        if (frameErr) errPulses++;
        if (fIf.ValidOut_SO && fIf.ReadyIn_SI) begin
          checks++;
          if (streamOn) xferCyc.push_back(cyc);
          if (sbQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame raw=%0h", fIf.Raw_DO);
          end else begin
            e = sbQ.pop_front();
            if (fIf.Raw_DO !== e.raw || fIf.ModeOut_SO !== e.mode
                || fIf.LabelOut_DO !== e.label) begin
              errors++;
              $display("FAIL frame got raw=%0h mode=%0h label=%0h want raw=%0h mode=%0h label=%0h",
                       fIf.Raw_DO, fIf.ModeOut_SO, fIf.LabelOut_DO,
                       e.raw, e.mode, e.label);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int e0;
    exp_t ex;

    vecs[0] = '{1'b1, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 2'd3, 4'd15, 32'hC33CA55A};
    vecs[1] = '{1'b0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 2'd2, 4'd9,  32'hC4C3C2C1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 2'd0, 4'd0,  32'hFF00FF00};
    vecs[3] = '{1'b1, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 2'd1, 4'd7,  32'hEFBEADDE};

    sIf.SampleValid_SI = 1'b0;
    sIf.FrameStart_SI  = 1'b0;
    sIf.Sample_DI      = '0;
    sIf.ModeIn_SI      = '0;
    sIf.LabelIn_DI     = '0;
    fIf.ReadyIn_SI     = 1'b1;

    fork
      monitor();
      begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", fIf.ValidOut_SO, 0);
    chk("rst_raw", fIf.Raw_DO, 0);
    chk("rst_mode", fIf.ModeOut_SO, 0);
    chk("rst_label", fIf.LabelOut_DO, 0);
    chk("rst_err", frameErr, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", sIf.SampleReady_SO, 1);

    sbQ.push_back('{32'h44332211, 2'd1, 4'd2});
    send(1, 8'h11, 1, 2);
    send(0, 8'h22, 1, 2);
    send(0, 8'h33, 1, 2);
    send(0, 8'h44, 1, 2);
    @(negedge clk);
    chk("t1_valid", fIf.ValidOut_SO, 1);
    chk("t1_raw", fIf.Raw_DO, 32'h44332211);
    chk("t1_mode", fIf.ModeOut_SO, 1);
    chk("t1_label", fIf.LabelOut_DO, 2);
    @(negedge clk);
    chk("t1_valid_drop", fIf.ValidOut_SO, 0);

    for (int v = 0; v < 4; v++) begin
      e0 = errPulses;
      sbQ.push_back('{vecs[v].expRaw, vecs[v].mode, vecs[v].label});
      send(vecs[v].fs, vecs[v].s0, vecs[v].mode, vecs[v].label);
      send(0, vecs[v].s1, vecs[v].mode, vecs[v].label);
      send(0, vecs[v].s2, vecs[v].mode, vecs[v].label);
      send(0, vecs[v].s3, vecs[v].mode, vecs[v].label);
      repeat (2) @(negedge clk);
      chk("vec_no_err", errPulses - e0, 0);
    end

    @(posedge clk);
    #1;
    fIf.ReadyIn_SI = 1'b0;
    sbQ.push_back('{32'h0D0C0B0A, 2'd2, 4'd5});
    send(1, 8'h0A, 2, 5);
    send(0, 8'h0B, 2, 5);
    send(0, 8'h0C, 2, 5);
    send(0, 8'h0D, 2, 5);
    sbQ.push_back('{32'hA4A3A2A1, 2'd1, 4'd3});
    send(1, 8'hA1, 1, 3);
    send(0, 8'hA2, 1, 3);
    send(0, 8'hA3, 1, 3);
    send(0, 8'hA4, 1, 3);
    @(negedge clk);
    chk("bp_ready_low", sIf.SampleReady_SO, 0);
    chk("bp_valid", fIf.ValidOut_SO, 1);
    chk("bp_hold_raw", fIf.Raw_DO, 32'h0D0C0B0A);
    chk("bp_hold_mode", fIf.ModeOut_SO, 2);
    @(posedge clk);
    #1;
    fIf.ReadyIn_SI = 1'b1;
    @(posedge clk);
    #1;
    fIf.ReadyIn_SI = 1'b0;
    @(negedge clk);
    chk("bp_next_raw", fIf.Raw_DO, 32'hA4A3A2A1);
    chk("bp_next_valid", fIf.ValidOut_SO, 1);
    chk("bp_ready_back", sIf.SampleReady_SO, 1);
    @(posedge clk);
    #1;
    fIf.ReadyIn_SI = 1'b1;
    repeat (2) @(negedge clk);

    e0 = errPulses;
    sbQ.push_back('{32'h08070605, 2'd3, 4'd1});
    send(1, 8'h01, 0, 0);
    send(0, 8'h02, 0, 0);
    send(1, 8'h05, 3, 1);
    send(0, 8'h06, 3, 1);
    send(0, 8'h07, 3, 1);
    send(0, 8'h08, 3, 1);
    repeat (3) @(negedge clk);
    chk("resync_err_pulses", errPulses - e0, 1);

    send(1, 8'h77, 0, 1);
    send(0, 8'h78, 0, 1);
    #3;
    rstN = 1'b0;
    #1;
    chk("midrst_valid", fIf.ValidOut_SO, 0);
    chk("midrst_raw", fIf.Raw_DO, 0);
    chk("midrst_label", fIf.LabelOut_DO, 0);
    #10;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    fIf.ReadyIn_SI = 1'b0;
    send(1, 8'h31, 1, 1);
    send(0, 8'h32, 1, 1);
    send(0, 8'h33, 1, 1);
    send(0, 8'h34, 1, 1);
    @(negedge clk);
    chk("vrst_pre_valid", fIf.ValidOut_SO, 1);
    #2;
    rstN = 1'b0;
    #1;
    chk("vrst_valid", fIf.ValidOut_SO, 0);
    chk("vrst_raw", fIf.Raw_DO, 0);
    chk("vrst_mode", fIf.ModeOut_SO, 0);
    chk("vrst_label", fIf.LabelOut_DO, 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    fIf.ReadyIn_SI = 1'b1;
    repeat (6) @(negedge clk);
    chk("vrst_no_stale", fIf.ValidOut_SO, 0);
    sbQ.push_back('{32'h93929190, 2'd2, 4'd6});
    send(1, 8'h90, 2, 6);
    send(0, 8'h91, 2, 6);
    send(0, 8'h92, 2, 6);
    send(0, 8'h93, 2, 6);
    repeat (2) @(negedge clk);

    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NCH; k++) begin
        ex.raw[k*RW +: RW] = streamData(f, k);
      end
      ex.mode  = MW'(f % 4);
      ex.label = LW'(f + 3);
      sbQ.push_back(ex);
    end
    streamOn = 1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NCH; k++) begin
        send(k == 0, streamData(f, k), MW'(f % 4), LW'(f + 3));
      end
    end
    repeat (3) @(negedge clk);
    streamOn = 0;
    chk("stream_xfers", xferCyc.size(), 8);
    for (int i = 1; i < xferCyc.size(); i++) begin
      chk("stream_spacing", xferCyc[i] - xferCyc[i-1], 4);
    end

    chk("sb_empty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raw_frame_assembler.md
Name: raw_frame_assembler

Overview:
- Upstream neighbour of feature_encoder.
- Collects per-channel raw samples arriving serially from the acquisition front-end, one sample per handshake, in channel order 0..INPUT_CHANNELS-1.
- Packs them into the parallel Raw vector with Mode/Label tags and hands each complete frame to feature_encoder over a valid/ready interface.
- Double-buffered, so a new frame can be gathered while the previous one waits on backpressure.

Parameters:
- RAW_WIDTH, `RAW_WIDTH (const.vh): bits per channel sample.
- INPUT_CHANNELS, `INPUT_CHANNELS (const.vh): channels per frame.
- MODE_WIDTH, `MODE_WIDTH: mode tag width.
- LABEL_WIDTH, `LABEL_WIDTH: label tag width.

Ports:
- Clk_CI, in, 1: clock; all state updates on rising edge.
- Reset_RBI, in, 1: asynchronous, active-low reset.
- SampleValid_SI, in, 1: sample offered.
- SampleReady_SO, out, 1: sample accepted when SampleValid_SI & SampleReady_SO.
- FrameStart_SI, in, 1: qualifies the offered sample as channel 0.
- Sample_DI, in, RAW_WIDTH: sample data.
- ModeIn_SI, in, MODE_WIDTH: mode tag, sampled with the channel-0 sample.
- LabelIn_DI, in, LABEL_WIDTH: label tag, sampled with the channel-0 sample.
- ValidOut_SO, out, 1: frame valid to feature_encoder.
- ReadyIn_SI, in, 1: feature_encoder ready.
- Raw_DO, out, RAW_WIDTH*INPUT_CHANNELS: channel k at bits [k*RAW_WIDTH +: RAW_WIDTH].
- ModeOut_SO, out, MODE_WIDTH: mode tag of the frame on Raw_DO.
- LabelOut_DO, out, LABEL_WIDTH: label tag of the frame on Raw_DO.
- FrameErr_SO, out, 1: one-cycle pulse on frame resync (partial frame dropped).

Behaviour:
- Reset (async, Reset_RBI=0): all outputs and state cleared.
  - ValidOut_SO=0, Raw_DO=0, ModeOut_SO=0, LabelOut_DO=0, FrameErr_SO=0.
  - Channel counter=0, assembly state COLLECT, SampleReady_SO=1 once released.
  - Reset mid-frame or with ValidOut_SO high discards everything; no frame is emitted after release.
- Assembly FSM, states COLLECT and FULL.
- COLLECT: each accepted sample is written to slot Cnt.
  - If FrameStart_SI=1: written to slot 0, mode/label latched, and Cnt set to 1.
  - Otherwise Cnt is incremented.
  - FrameStart_SI=1 with Cnt!=0: the partial frame is dropped, the sample restarts the frame as channel 0, and FrameErr_SO pulses for 1 cycle.
  - Sample at Cnt=0 without FrameStart_SI: accepted as channel 0 with mode/label latched; no error.
- Last sample (Cnt=INPUT_CHANNELS-1) accepted:
  - Output slot free (ValidOut_SO=0, or ReadyIn_SI=1 this cycle): the frame moves to the output registers on the same edge. ValidOut_SO=1 the following cycle (latency 1 cycle from last-sample acceptance). Cnt=0, stay COLLECT.
  - Output slot occupied: go to FULL.
- FULL: SampleReady_SO=0. On the first cycle ReadyIn_SI=1, the output takes the assembled frame (ValidOut_SO stays 1 with new data), Cnt=0, back to COLLECT.
- SampleReady_SO=1 in COLLECT and 0 in FULL; it is a registered state decode, not dependent on ReadyIn_SI combinationally.
- Output handshake:
  - Raw_DO, ModeOut_SO and LabelOut_DO are held stable while ValidOut_SO=1 and ReadyIn_SI=0.
  - ValidOut_SO drops after a transfer unless a new frame is loaded on the same edge.
  - Back-to-back frames with ReadyIn_SI tied 1 sustain 1 sample/cycle with no bubbles.
- Simultaneous output drain and last-sample accept: handled as slot free; no frame lost or duplicated.
- Counter width ceilLog2(INPUT_CHANNELS); INPUT_CHANNELS=1 is legal (every accepted sample completes a frame).

Decomposition:
- RAW_WIDTH, INPUT_CHANNELS, MODE_WIDTH, LABEL_WIDTH and `ceilLog2 come from the shared const.vh.
- Add FSM state encodings to const.vh as `RFA_COLLECT and `RFA_FULL.
- One natural sub-module: frame_output_reg, a 1-entry valid/ready holding register for data+tags, reusable by other stages.

Test Plan:
- INPUT_CHANNELS=4, RAW_WIDTH=8, ReadyIn_SI=1; feed 0x11,0x22,0x33,0x44 with FrameStart_SI on the first, Mode=1, Label=2 -> one cycle after 0x44 is accepted: ValidOut_SO=1, Raw_DO=0x44332211, ModeOut_SO=1, LabelOut_DO=2, high for exactly 1 cycle.
- ReadyIn_SI=0 after frame A; stream frame B (0xA1..0xA4) -> SampleReady_SO=0 after 0xA4 accepted; Raw_DO holds frame A. Raise ReadyIn_SI for 1 cycle -> next cycle Raw_DO=0xA4A3A2A1, SampleReady_SO=1.
- Send 0x01,0x02 then FrameStart_SI with 0x05, then 0x06,0x07,0x08 -> FrameErr_SO pulses once; emitted frame Raw_DO=0x08070605.
- Assert Reset_RBI low asynchronously mid-frame (after 2 samples) and while ValidOut_SO=1 -> outputs zero immediately; after release a full new frame emits correctly with no stale data.
- Continuous stream of 8 frames, SampleValid_SI and ReadyIn_SI tied 1 -> 8 ValidOut_SO transfers, spaced 4 cycles apart, data matching a file-driven reference model, zero fails reported.
